// File: rtl/player_link_tx_pkg.sv
// ---- player_link_tx_pkg : shared player-state types and link framing helpers | rev 1.0 ----
`default_nettype none

package player_link_tx_pkg;

  typedef logic [88:0] data_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
  } location_t;

  localparam logic [7:0] LINK_SYNC_BYTE     = 8'hA5;
  localparam int         LINK_PAYLOAD_BYTES = 12;

  typedef logic [8*LINK_PAYLOAD_BYTES-1:0] payload_t;

  // Payload byte k counts from the most-significant end (k=0 goes on the wire first).
  function automatic logic [7:0] payload_byte(payload_t p, logic [3:0] k);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < LINK_PAYLOAD_BYTES; i++) begin
      if (k == 4'(i)) b = p[8*(LINK_PAYLOAD_BYTES-1-i) +: 8];
    end
    return b;
  endfunction

  function automatic logic [7:0] payload_checksum(payload_t p);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < LINK_PAYLOAD_BYTES; i++) c = c ^ p[8*i +: 8];
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/player_link_tx_uart.sv
// ---- uart_byte_tx : 8N1 byte serialiser, accepts a new byte in its final stop cycle | rev 1.0 ----
`default_nettype none

module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 644
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid_in,
  output logic       tx_out,
  output logic       byte_done_out
);

  localparam int             CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]  LAST_CLK     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  PRE_LAST_CLK = CW'(CLKS_PER_BIT - 2);

  logic          r_active;
  logic [8:0]    r_shift;
  logic [3:0]    r_bit;
  logic [CW-1:0] r_clk;
  logic          r_tx;
  logic          w_last;

  assign w_last = r_active && (r_bit == 4'd9) && (r_clk == LAST_CLK);
  // Done fires one cycle early so the caller can queue the next byte into the last stop cycle.
  assign byte_done_out = r_active && (r_bit == 4'd9) && (r_clk == PRE_LAST_CLK);
  assign tx_out        = r_tx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_shift  <= '1;
      r_bit    <= 4'd0;
      r_clk    <= '0;
      r_tx     <= 1'b1;
    end else if (byte_valid_in && (!r_active || w_last)) begin
      r_active <= 1'b1;
      r_shift  <= {1'b1, byte_in};
      r_bit    <= 4'd0;
      r_clk    <= '0;
      r_tx     <= 1'b0;
    end else if (r_active) begin
      if (r_clk == LAST_CLK) begin
        r_clk <= '0;
        if (r_bit == 4'd9) begin
          r_active <= 1'b0;
          r_tx     <= 1'b1;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_clk <= r_clk + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/player_link_tx.sv
// ---- player_link_tx : frames player state as sync + 12 payload + checksum bytes | rev 1.0 ----
`default_nettype none

module player_link_tx
  import player_link_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 644
) (
  input  logic  clk_pixel_in,
  input  logic  rst_in,
  input  data_t player_data_in,
  input  logic  player_scored_in,
  input  logic  data_in_valid,
  output logic  tx_out,
  output logic  busy_out,
  output logic  packet_sent_out
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_SEND = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t     r_state;
  logic [3:0] r_idx;
  logic       r_busy;
  logic       r_sent;
  logic       r_pend_valid;
  logic       r_pend_scored;
  data_t      r_pend_data;
  payload_t   r_payload;
  logic [7:0] r_checksum;

  payload_t   w_load_payload;
  logic [7:0] w_byte;
  logic       w_byte_valid;
  logic       w_byte_done;

  assign w_load_payload  = {6'b0, r_pend_scored, r_pend_data};
  assign busy_out        = r_busy;
  assign packet_sent_out = r_sent;

  // In NEXT with index k the byte being queued is k+1: payload byte k, or the checksum after the last.
  assign w_byte_valid = (r_state == ST_LOAD) || ((r_state == ST_NEXT) && (r_idx != 4'd13));

  always_comb begin
    w_byte = LINK_SYNC_BYTE;
    if (r_state == ST_NEXT) begin
      if (r_idx == 4'd12) w_byte = r_checksum;
      else                w_byte = payload_byte(r_payload, r_idx);
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      r_state       <= ST_IDLE;
      r_idx         <= 4'd0;
      r_busy        <= 1'b0;
      r_sent        <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_scored <= 1'b0;
      r_pend_data   <= '0;
      r_payload     <= '0;
      r_checksum    <= 8'h00;
    end else begin
      r_sent <= 1'b0;

      // Pending slot: newest data wins, but a score event survives until it is loaded.
      if (data_in_valid) begin
        r_pend_data   <= player_data_in;
        r_pend_scored <= player_scored_in |
                         (r_pend_valid & (r_state != ST_LOAD) & r_pend_scored);
        r_pend_valid  <= 1'b1;
      end else if (r_state == ST_LOAD) begin
        r_pend_valid  <= 1'b0;
        r_pend_scored <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (data_in_valid) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_payload  <= w_load_payload;
          r_checksum <= payload_checksum(w_load_payload);
          r_idx      <= 4'd0;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          if (w_byte_done) r_state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (r_idx == 4'd13) begin
            r_state <= ST_DONE;
            r_sent  <= 1'b1;
          end else begin
            r_idx   <= r_idx + 4'd1;
            r_state <= ST_SEND;
          end
        end
        ST_DONE: begin
          if (r_pend_valid || data_in_valid) begin
            r_state <= ST_LOAD;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart (
    .clk           (clk_pixel_in),
    .rst           (rst_in),
    .byte_in       (w_byte),
    .byte_valid_in (w_byte_valid),
    .tx_out        (tx_out),
    .byte_done_out (w_byte_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_player_link_tx.sv
// ---- tb_player_link_tx : byte scoreboard fed by directed packets, checked by a line decoder | rev 1.0 ----
`default_nettype none
`timescale 1ns/1ps

module tb_player_link_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 140 * CPB;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        valid;
  logic        scored;
  logic [88:0] data;
  logic        tx_out;
  logic        busy_out;
  logic        sent_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sent_cnt = 0;
  int rst_epoch = 0;
  int busy_drops = 0;
  bit watch_busy = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  player_link_tx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk_pixel_in     (clk),
    .rst_in           (rst_in),
    .player_data_in   (data),
    .player_scored_in (scored),
    .data_in_valid    (valid),
    .tx_out           (tx_out),
    .busy_out         (busy_out),
    .packet_sent_out  (sent_out)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_in) rst_epoch <= rst_epoch + 1;
  end

  always @(negedge clk) begin
    if (sent_out === 1'b1) sent_cnt <= sent_cnt + 1;
    if (watch_busy && busy_out !== 1'b1) busy_drops <= busy_drops + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit cond_met(input int sel);
    case (sel)
      0:       return tx_out === 1'b0;
      1:       return sent_out === 1'b1;
      default: return busy_out === 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input int bound, input string name);
    int n;
    n = 0;
    while (!cond_met(sel) && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!cond_met(sel)) begin
      errors++;
      $display("FAIL %s: condition not reached, got timeout expected event within %0d cycles", name, bound);
    end
  endtask

  task automatic push_pkt(input logic [88:0] d, input logic s);
    logic [95:0] p;
    logic [7:0]  b;
    logic [7:0]  cs;
    p  = {6'b0, s, d};
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 12; i++) begin
      b  = p[95-8*i -: 8];
      cs = cs ^ b;
      exp_q.push_back(b);
    end
    exp_q.push_back(cs);
  endtask

  task automatic send(input logic [88:0] d, input logic s);
    data   = d;
    scored = s;
    valid  = 1'b1;
    @(negedge clk);
    valid  = 1'b0;
  endtask

  // Line decoder: samples mid-bit on falling edges, discards a byte cut short by reset.
  logic [7:0] rx_b;
  logic [7:0] rx_exp;
  logic [7:0] rx_pkt[14];
  logic [7:0] rx_cs;
  logic       rx_stop;
  int         rx_pos = 0;
  int         rx_ep;

  initial begin : rx_monitor
    forever begin
      @(negedge clk);
      if (tx_out === 1'b0 && rst_in === 1'b0) begin
        rx_ep = rst_epoch;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_b[i] = tx_out;
        end
        repeat (CPB) @(negedge clk);
        rx_stop = tx_out;
        if (rst_epoch != rx_ep) begin
          rx_pos = 0;
        end else begin
          check("rx_stop_bit", {31'b0, rx_stop}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rx_unexpected_byte: got %0h expected no byte", rx_b);
          end else begin
            rx_exp = exp_q.pop_front();
            check("rx_byte", {24'b0, rx_b}, {24'b0, rx_exp});
          end
          rx_pkt[rx_pos] = rx_b;
          rx_pos++;
          if (rx_pos == 14) begin
            rx_cs = 8'h00;
            for (int i = 1; i <= 12; i++) rx_cs = rx_cs ^ rx_pkt[i];
            check("rx_checksum", {24'b0, rx_pkt[13]}, {24'b0, rx_cs});
            rx_pos = 0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got no finish expected finish before 900000 ns");
    $fatal(1, "watchdog expired");
  end

  int          c0, c1, c2, s0, lows;
  logic [95:0] rnd;
  logic [88:0] d_p, d_a, d_b;

  initial begin : stimulus
    rst_in = 1'b1;
    valid  = 1'b0;
    scored = 1'b0;
    data   = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", {31'b0, tx_out}, 32'd1);
    check("reset_busy", {31'b0, busy_out}, 32'd0);
    check("reset_sent", {31'b0, sent_out}, 32'd0);
    rst_in = 1'b0;
    repeat (5) @(negedge clk);

    // Single packet with data=1: sync, eleven zeros, 01, checksum 01.
    exp_q.push_back(8'hA5);
    repeat (11) exp_q.push_back(8'h00);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h01);
    s0 = sent_cnt;
    c0 = cyc;
    send(89'h1, 1'b0);
    check("busy_next_cycle", {31'b0, busy_out}, 32'd1);
    wait_cond(0, 5, "start_bit_t1");
    c1 = cyc;
    check("start_latency_le3", {31'b0, (c1 - c0) <= 3}, 32'd1);
    wait_cond(1, FRAME + 20, "sent_t1");
    c2 = cyc;
    check("frame_length", c2 - c1, FRAME);
    @(negedge clk);
    check("sent_one_cycle", {31'b0, sent_out}, 32'd0);
    check("busy_drops_idle", {31'b0, busy_out}, 32'd0);
    check("sent_count_t1", sent_cnt - s0, 32'd1);
    repeat (5) @(negedge clk);

    // Score bit only: MSB payload byte carries it as 02.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h02);
    repeat (11) exp_q.push_back(8'h00);
    exp_q.push_back(8'h02);
    send(89'h0, 1'b1);
    wait_cond(1, FRAME + 20, "sent_t2");
    wait_cond(2, 5, "idle_t2");
    repeat (5) @(negedge clk);

    // Two updates mid-packet: B overwrites A but inherits A's score event.
    d_p = 89'h1_2345_6789_ABCD_EF01_2345;
    d_a = 89'h0_AAAA_5555_AAAA_5555_AAAA;
    d_b = 89'h1_5A5A_C3C3_0F0F_F0F0_1234;
    push_pkt(d_p, 1'b0);
    push_pkt(d_b, 1'b1);
    s0 = sent_cnt;
    send(d_p, 1'b0);
    watch_busy = 1'b1;
    repeat (100) @(negedge clk);
    send(d_a, 1'b1);
    repeat (100) @(negedge clk);
    send(d_b, 1'b0);
    wait_cond(1, FRAME + 20, "sent_t3a");
    @(negedge clk);
    wait_cond(1, FRAME + 20, "sent_t3b");
    watch_busy = 1'b0;
    wait_cond(2, 5, "idle_t3");
    check("busy_no_drop", busy_drops, 32'd0);
    check("sent_count_t3", sent_cnt - s0, 32'd2);
    repeat (5) @(negedge clk);

    // New request lands exactly in the DONE cycle.
    push_pkt(89'h0_0000_0000_0000_0000_BEEF, 1'b0);
    send(89'h0_0000_0000_0000_0000_BEEF, 1'b0);
    wait_cond(1, FRAME + 20, "sent_t4a");
    c0 = cyc;
    push_pkt(89'h1_FFFF_0000_FFFF_0000_FFFF, 1'b1);
    send(89'h1_FFFF_0000_FFFF_0000_FFFF, 1'b1);
    check("busy_in_load", {31'b0, busy_out}, 32'd1);
    wait_cond(0, 10, "start_t4b");
    check("done_gap_le3", {31'b0, (cyc - c0) <= 3}, 32'd1);
    wait_cond(1, FRAME + 20, "sent_t4b");
    wait_cond(2, 5, "idle_t4");
    repeat (5) @(negedge clk);

    // Reset in the middle of byte 5, with a request in the reset cycle that must be ignored.
    push_pkt(89'h0_1111_2222_3333_4444_5555, 1'b1);
    send(89'h0_1111_2222_3333_4444_5555, 1'b1);
    wait_cond(0, 5, "start_t5");
    repeat (5 * 10 * CPB + 10) @(negedge clk);
    rst_in = 1'b1;
    data   = '1;
    valid  = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    valid  = 1'b0;
    check("rst_mid_tx", {31'b0, tx_out}, 32'd1);
    check("rst_mid_busy", {31'b0, busy_out}, 32'd0);
    s0   = sent_cnt;
    lows = 0;
    repeat (FRAME + 140) begin
      @(negedge clk);
      if (tx_out !== 1'b1) lows++;
    end
    check("rst_line_idle", lows, 32'd0);
    check("rst_no_sent", sent_cnt - s0, 32'd0);
    check("rst_bytes_seen", exp_q.size(), 32'd9);
    exp_q.delete();

    // Random packets through the decoder.
    for (int n = 0; n < 100; n++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      push_pkt(rnd[88:0], rnd[89]);
      send(rnd[88:0], rnd[89]);
      wait_cond(1, FRAME + 20, "sent_rand");
      wait_cond(2, 5, "idle_rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (50) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
